// File: rtl/core_pkg.sv
// Shared core definitions: data width, register address width, load funct3 codes,
// the writeback queue entry type and the load extension helper.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic [2:0]        funct3;
  } wb_entry_t;

  // Unknown load types pass the raw data through untouched.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3,
                                                  input logic [XLEN-1:0] data);
    logic [XLEN-1:0] res;
    res = data;
    case (funct3)
      F3_LB:   res = {{(XLEN-8){data[7]}}, data[7:0]};
      F3_LH:   res = {{(XLEN-16){data[15]}}, data[15:0]};
      F3_LW:   res = data;
      F3_LBU:  res = {{(XLEN-8){1'b0}}, data[7:0]};
      F3_LHU:  res = {{(XLEN-16){1'b0}}, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// Synchronous FIFO of writeback entries holding queued load responses (raw data + funct3).
module core_wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_sync,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t wdata,
  output wb_entry_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst_sync) push |-> !full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst_sync) pop |-> !empty);

endmodule

// File: rtl/core_wb_unit.sv
// Writeback unit: merges ALU results with queued load responses onto the register file
// write port. `CORE_WB_SCOREBOARD_EN adds a register-busy scoreboard.
module core_wb_unit
  import core_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 4,
  parameter int unsigned XLEN           = 32
) (
  input  logic                              clk,
  input  logic                              rst_sync,
  input  logic                              stall_n,
  input  logic                              alu_valid,
  input  logic [4:0]                        alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              lsu_valid,
  output logic                              lsu_ready,
  input  logic [4:0]                        lsu_rd,
  input  logic [XLEN-1:0]                   lsu_data,
  input  logic [2:0]                        lsu_funct3,
  output logic [4:0]                        reg_waddr,
  output logic [XLEN-1:0]                   reg_wdata,
  output logic                              reg_wen,
`ifdef CORE_WB_SCOREBOARD_EN
  input  logic                              sb_set_valid,
  input  logic [4:0]                        sb_set_rd,
  output logic [31:0]                       reg_busy,
`endif
  output logic [$clog2(LSU_FIFO_DEPTH):0]   lsu_pending
);

  wb_entry_t fifo_in;
  wb_entry_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      pop;
  logic      alu_sel;

  assign lsu_ready = !fifo_full && !rst_sync;
  assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign alu_sel   = alu_valid && (alu_rd != '0);
  assign pop       = stall_n && !rst_sync && !alu_sel && !fifo_empty;

  assign fifo_in = '{rd: lsu_rd, data: lsu_data, funct3: lsu_funct3};

  core_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_sync (rst_sync),
    .push     (push),
    .pop      (pop),
    .wdata    (fifo_in),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (lsu_pending)
  );

  // While stalled the registered write is held so it commits once the stall releases.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      reg_wen   <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
    end else if (stall_n) begin
      if (alu_sel) begin
        reg_wen   <= 1'b1;
        reg_waddr <= alu_rd;
        reg_wdata <= alu_data;
      end else if (!fifo_empty) begin
        reg_wen   <= 1'b1;
        reg_waddr <= fifo_head.rd;
        reg_wdata <= load_extend(fifo_head.funct3, fifo_head.data);
      end else begin
        reg_wen   <= 1'b0;
      end
    end
  end

`ifdef CORE_WB_SCOREBOARD_EN
  logic [31:0] busy_set;
  logic [31:0] busy_clr;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (reg_wen && stall_n)                busy_clr[reg_waddr] = 1'b1;
    if (sb_set_valid && (sb_set_rd != '0)) busy_set[sb_set_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle set of a committing register wins.
  always_ff @(posedge clk) begin
    if (rst_sync) reg_busy <= '0;
    else          reg_busy <= ((reg_busy & ~busy_clr) | busy_set) & ~32'h1;
  end
`endif

  a_wen_rd_nonzero: assert property (@(posedge clk) disable iff (rst_sync)
                                     reg_wen |-> (reg_waddr != '0));
  a_alu_no_stall:   assert property (@(posedge clk) disable iff (rst_sync)
                                     alu_valid |-> stall_n);
  a_push_not_full:  assert property (@(posedge clk) disable iff (rst_sync)
                                     push |-> !fifo_full);

endmodule

// File: tb/tb_core_wb_unit.sv
// Randomized scoreboard bench for core_wb_unit; compile with +define+CORE_WB_SCOREBOARD_EN
// to also exercise the busy scoreboard.
module tb_core_wb_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic        stall_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic [2:0]  lsu_pending;
`ifdef CORE_WB_SCOREBOARD_EN
  logic        sb_set_valid = 1'b0;
  logic [4:0]  sb_set_rd = '0;
  logic [31:0] reg_busy;
`endif

  core_wb_unit #(
    .LSU_FIFO_DEPTH (DEPTH),
    .XLEN           (32)
  ) dut (
    .clk          (clk),
    .rst_sync     (rst_sync),
    .stall_n      (stall_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_funct3   (lsu_funct3),
    .reg_waddr    (reg_waddr),
    .reg_wdata    (reg_wdata),
    .reg_wen      (reg_wen),
`ifdef CORE_WB_SCOREBOARD_EN
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .reg_busy     (reg_busy),
`endif
    .lsu_pending  (lsu_pending)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic [2:0] f3; } ld_t;

  wr_t  exp_q[$];
  ld_t  mq[$];
  int   checks = 0;
  int   failures = 0;
  bit   primed = 1'b0;
  bit   mw_valid = 1'b0;
  logic [4:0]  mw_addr = '0;
  logic [31:0] busy_m = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  // Load extension from the architectural definition, using integer arithmetic.
  function automatic logic [31:0] ref_ext(logic [2:0] f3, logic [31:0] d);
    longint v;
    case (f3)
      3'b000: begin v = longint'(d % 256);   if (v > 127)   v -= 256;   return 32'(v); end
      3'b001: begin v = longint'(d % 65536); if (v > 32767) v -= 65536; return 32'(v); end
      3'b100: return d % 256;
      3'b101: return d % 65536;
      default: return d;
    endcase
  endfunction

  task automatic step(input bit r, input bit st,
                      input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [2:0] lf3,
                      input bit sv, input logic [4:0] srd);
    bit accept;
    ld_t e;
    @(posedge clk); #1;
    rst_sync   = r;
    stall_n    = st;
    alu_valid  = av & st;
    alu_rd     = ard;
    alu_data   = ad;
    lsu_valid  = lv;
    lsu_rd     = lrd;
    lsu_data   = ld;
    lsu_funct3 = lf3;
`ifdef CORE_WB_SCOREBOARD_EN
    sb_set_valid = sv;
    sb_set_rd    = srd;
`endif
    #1;
    if (primed) begin
      check("lsu_ready", 32'(lsu_ready), 32'(!r && mq.size() < DEPTH));
      check("lsu_pending", 32'(lsu_pending), 32'(mq.size()));
      check("reg_wen", 32'(reg_wen), 32'(mw_valid));
`ifdef CORE_WB_SCOREBOARD_EN
      check("reg_busy", reg_busy, busy_m);
`endif
    end
    if (r) begin
      mq.delete();
      exp_q.delete();
      mw_valid = 1'b0;
      busy_m   = '0;
      primed   = 1'b1;
    end else begin
      accept = lv && (mq.size() < DEPTH);
      if (st && mw_valid) busy_m[mw_addr] = 1'b0;
      if (sv && srd != 0) busy_m[srd] = 1'b1;
      if (st) begin
        if (av && ard != 0) begin
          mw_valid = 1'b1; mw_addr = ard;
          exp_q.push_back('{rd: ard, data: ad});
        end else if (mq.size() > 0) begin
          e = mq.pop_front();
          mw_valid = 1'b1; mw_addr = e.rd;
          exp_q.push_back('{rd: e.rd, data: ref_ext(e.f3, e.data)});
        end else begin
          mw_valid = 1'b0;
        end
      end
      if (accept && lrd != 0) mq.push_back('{rd: lrd, data: ld, f3: lf3});
    end
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) step(0, st, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  wr_t mon_e;
  always @(negedge clk) begin
    if (!rst_sync && stall_n && reg_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got x%0d=0x%08h expected none at %0t",
                 reg_waddr, reg_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_addr", 32'(reg_waddr), 32'(mon_e.rd));
        check("wb_data", reg_wdata, mon_e.data);
      end
    end
  end

  initial begin
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 1);

    // ALU only
    step(0, 1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
    idle(2, 1);

    // ALU and LB load together: ALU first, extended load next
    step(0, 1, 1, 3, 32'hCAFE, 1, 7, 32'h80, 3'b000, 0, 0);
    idle(3, 1);

    // LHU / LH / LBU of the same raw word, then LW and an undefined funct3
    step(0, 1, 0, 0, 0, 1, 9,  32'hFFFF8001, 3'b101, 0, 0);
    step(0, 1, 0, 0, 0, 1, 10, 32'hFFFF8001, 3'b001, 0, 0);
    step(0, 1, 0, 0, 0, 1, 11, 32'hFFFF8001, 3'b100, 0, 0);
    step(0, 1, 0, 0, 0, 1, 12, 32'h8765_4321, 3'b010, 0, 0);
    step(0, 1, 0, 0, 0, 1, 13, 32'hFFFF_FF85, 3'b111, 0, 0);
    idle(4, 1);

    // ALU x4 held across a stall while 5 loads try to enter a 4-deep queue
    step(0, 1, 1, 4, 32'h4444, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, 0, 1, 5'(14 + i), 32'h100 + 32'(i), 3'b010, 0, 0);
    idle(6, 1);

    // rd=0 on both sources
    step(0, 1, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 3'b010, 0, 0);
    idle(2, 1);

    // Reset with three queued loads and a held write
    step(0, 1, 1, 20, 32'h2020, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 1, 5'(21 + i), 32'hAA, 3'b000, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 1);

`ifdef CORE_WB_SCOREBOARD_EN
    // Set x6 busy at issue, load to x6 commits and clears it
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    step(0, 1, 0, 0, 0, 1, 6, 32'h66, 3'b010, 0, 0);
    idle(3, 1);
    // Commit of x6 in the same cycle as a new set: stays busy
    step(0, 1, 1, 6, 32'h6, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    idle(2, 1);
`endif

    for (int i = 0; i < 800; i++) begin
      bit st;
      logic [2:0] f3;
      st = ($urandom_range(0, 3) != 0);
      f3 = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 149) == 0), st,
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 31)), $urandom, f3,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end

    idle(DEPTH + 6, 1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("model_queue_empty", 32'(lsu_pending), 32'(mq.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
